cruise_controller: RTL

CRUISE_CONTROLLER -- requirements
Module: cruise_controller

---
 rtl/cruise_pkg.sv | 22 ++
 rtl/cruise_accel_law.sv | 57 +++++
 rtl/cruise_controller.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cruise_pkg.sv
// Shared encodings and tuning constants for the cruise controller.
package cruise_pkg;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_STANDBY  = 2'd1,
        ST_ACTIVE   = 2'd2,
        ST_OVERRIDE = 2'd3
    } cruise_state_t;

    localparam logic [3:0] GEAR_D    = 4'd12;

    localparam logic [7:0] MIN_SET   = 8'd30;
    localparam logic [7:0] MAX_SET   = 8'd180;
    localparam logic [7:0] SET_STEP  = 8'd2;

    localparam logic [7:0] BASE_OFS  = 8'd10;
    localparam logic [7:0] GAIN      = 8'd4;
    localparam logic [7:0] OVR_HYST  = 8'd8;
    localparam logic [7:0] RAMP_STEP = 8'd8;

endpackage

// File: rtl/cruise_accel_law.sv
// Combinational throttle law: clamped proportional target plus optional slew limit.
// Build option CRUISE_RAMP_EN limits each update to RAMP_STEP; otherwise the target loads directly.
module cruise_accel_law
    import cruise_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] set_speed,
    input  logic [DATA_W-1:0] speed,
    input  logic [DATA_W-1:0] ctrl_accel,
    output logic [DATA_W-1:0] next_accel
);

    localparam int CALC_W = 12;

    localparam logic signed [CALC_W-1:0] BASE_S = $signed(CALC_W'(BASE_OFS));
    localparam logic signed [CALC_W-1:0] GAIN_S = $signed(CALC_W'(GAIN));
    localparam logic signed [CALC_W-1:0] MAX_S  = $signed(CALC_W'((1 << DATA_W) - 1));
`ifdef CRUISE_RAMP_EN
    localparam logic signed [CALC_W-1:0] STEP_LIM = $signed(CALC_W'(RAMP_STEP));
`else
    // A limit wider than the whole output range makes the step equal the full error.
    localparam logic signed [CALC_W-1:0] STEP_LIM = $signed(CALC_W'(1 << DATA_W));
`endif

    function automatic logic signed [CALC_W-1:0] widen(input logic [DATA_W-1:0] v);
        return $signed({{(CALC_W-DATA_W){1'b0}}, v});
    endfunction

    function automatic logic [DATA_W-1:0] sat_unsigned(input logic signed [CALC_W-1:0] v);
        if (v[CALC_W-1])
            return '0;
        if (v > MAX_S)
            return '1;
        return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [CALC_W-1:0] limit_step(input logic signed [CALC_W-1:0] d);
        if (d > STEP_LIM)
            return STEP_LIM;
        if (d < -STEP_LIM)
            return -STEP_LIM;
        return d;
    endfunction

    logic signed [CALC_W-1:0] err;
    logic signed [CALC_W-1:0] target_raw;
    logic        [DATA_W-1:0] target;

    always_comb begin
        err        = widen(set_speed) - widen(speed);
        target_raw = widen(set_speed) + BASE_S + err * GAIN_S;
        target     = sat_unsigned(target_raw);
        next_accel = sat_unsigned(widen(ctrl_accel) + limit_step(widen(target) - widen(ctrl_accel)));
    end

endmodule

// File: rtl/cruise_controller.sv
// Cruise control FSM with set-speed tracking, driver override and registered throttle output.
// Build option CRUISE_RAMP_EN (see cruise_accel_law) slew-limits the control law.
module cruise_controller
    import cruise_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              engine_on,
    input  logic              tick_speed,
    input  logic [3:0]        current_gear,
    input  logic [DATA_W-1:0] speed,
    input  logic [DATA_W-1:0] adc_accel,
    input  logic              is_brake_normal,
    input  logic              is_brake_hard,
    input  logic              btn_main,
    input  logic              btn_set,
    input  logic              btn_resume,
    input  logic              btn_cancel,
    output logic [DATA_W-1:0] accel_cmd,
    output logic [DATA_W-1:0] set_speed,
    output logic [1:0]        cruise_state,
    output logic              cruise_active
);

    cruise_state_t     state, state_nxt;
    logic [DATA_W-1:0] ctrl_accel, ctrl_nxt, set_nxt, accel_nxt, law_accel;
    logic              gear_d, exit_evt, set_only, resume_only, ovr_enter;

    function automatic logic [DATA_W-1:0] sat_step_down(input logic [DATA_W-1:0] s);
        return (s <= MIN_SET + SET_STEP) ? MIN_SET : s - SET_STEP;
    endfunction

    function automatic logic [DATA_W-1:0] sat_step_up(input logic [DATA_W-1:0] s);
        return (s >= MAX_SET - SET_STEP) ? MAX_SET : s + SET_STEP;
    endfunction

    cruise_accel_law #(.DATA_W(DATA_W)) u_law (
        .set_speed  (set_speed),
        .speed      (speed),
        .ctrl_accel (ctrl_accel),
        .next_accel (law_accel)
    );

    always_comb begin
        state_nxt   = state;
        set_nxt     = set_speed;
        ctrl_nxt    = ctrl_accel;
        gear_d      = (current_gear == GEAR_D);
        exit_evt    = is_brake_normal | is_brake_hard | btn_cancel | ~gear_d;
        set_only    = btn_set & ~btn_resume;
        resume_only = btn_resume & ~btn_set;
        // 9-bit compare so ctrl_accel near full scale cannot wrap the threshold.
        ovr_enter   = {1'b0, adc_accel} > ({1'b0, ctrl_accel} + {1'b0, OVR_HYST});

        if (!engine_on) begin
            state_nxt = ST_OFF;
            set_nxt   = '0;
            ctrl_nxt  = '0;
        end else if (btn_main) begin
            state_nxt = (state == ST_OFF) ? ST_STANDBY : ST_OFF;
            set_nxt   = '0;
            ctrl_nxt  = '0;
        end else begin
            unique case (state)
                ST_OFF: ;
                ST_STANDBY: begin
                    if (set_only && gear_d && speed >= MIN_SET && speed <= MAX_SET) begin
                        state_nxt = ST_ACTIVE;
                        set_nxt   = speed;
                        ctrl_nxt  = speed + BASE_OFS;
                    end else if (resume_only && gear_d && set_speed != '0) begin
                        state_nxt = ST_ACTIVE;
                        ctrl_nxt  = set_speed + BASE_OFS;
                    end
                end
                ST_ACTIVE: begin
                    if (exit_evt)
                        state_nxt = ST_STANDBY;
                    else if (set_only)
                        set_nxt = sat_step_down(set_speed);
                    else if (resume_only)
                        set_nxt = sat_step_up(set_speed);
                    else if (ovr_enter)
                        state_nxt = ST_OVERRIDE;
                    if (tick_speed && state_nxt == ST_ACTIVE)
                        ctrl_nxt = law_accel;
                end
                ST_OVERRIDE: begin
                    if (exit_evt)
                        state_nxt = ST_STANDBY;
                    else if (adc_accel <= ctrl_accel)
                        state_nxt = ST_ACTIVE;
                end
                default: state_nxt = ST_OFF;
            endcase
        end

        // Output follows the state being entered so a transition shows up one clock later.
        accel_nxt = (state_nxt == ST_ACTIVE) ? ctrl_nxt : adc_accel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_OFF;
            set_speed  <= '0;
            ctrl_accel <= '0;
            accel_cmd  <= '0;
        end else begin
            state      <= state_nxt;
            set_speed  <= set_nxt;
            ctrl_accel <= ctrl_nxt;
            accel_cmd  <= accel_nxt;
        end
    end

    assign cruise_state  = state;
    assign cruise_active = (state == ST_ACTIVE) || (state == ST_OVERRIDE);

endmodule
